mem_bus_arbiter: RTL and testbench

- Shares the single data-memory bus between the instruction-fetch requester and the load/store requester.
- Decodes the memory-mapped IO window and routes those accesses to the IO register block instead of memory.
- Handles variable-latency memory (busy handshake) and bus timeout.
- Sits between the core's fetch/LSU ports and the memory bus / IO block.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_timeout_ctr.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM states, bus owners,
// the NOP returned for illegal fetches and the IO window helper.
package bus_arb_pkg;

   typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;
   typedef enum logic {FETCH, DATA} owner_t;

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_IO_BASE = 32'hFFFF_FFF0;

   // The IO window is 16 bytes, so only the upper 28 address bits take part.
   function automatic logic inIoWindow(input logic [27:0] addrHi, input logic [27:0] baseHi);
      return addrHi == baseHi;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// Counts busy cycles of a memory access; expired_o flags the busy cycle that
// reaches TIMEOUT_CYCLES so the arbiter can abort in that same cycle.
module bus_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = en_i && (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the data-memory bus between fetch and load/store, diverts the IO
// window to the IO register block, and handles busy wait states and timeouts.
module mem_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] IO_BASE        = DEFAULT_IO_BASE
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic        io_read,
   output logic        io_write,
   output logic [1:0]  io_addr,
   output logic [31:0] io_wdata,
   input  logic [31:0] io_rdata,
   output logic        bus_err
);

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   owner_t      last_grant_q, last_grant_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic        io_read_q, io_read_d;
   logic        io_write_q, io_write_d;
   logic        if_done_q, if_done_d;
   logic        d_done_q, d_done_d;
   logic        bus_err_q, bus_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        finish;
   logic        finishErr;
   logic [31:0] finishData;
   logic        dataPending;
   logic        tmoExpired;

   bus_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .nrst     (nrst),
      .clear_i  (state_q != MEM),
      .en_i     ((state_q == MEM) && mem_busy),
      .expired_o(tmoExpired)
   );

   assign dataPending = d_read || d_write;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      io_read_d    = 1'b0;
      io_write_d   = 1'b0;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;
      bus_err_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      finish       = 1'b0;
      finishErr    = 1'b0;
      finishData   = '0;

      unique case (state_q)
         IDLE: begin
            // On a conflict the requester that did not win last time is served.
            if (dataPending && (!if_req || last_grant_q == FETCH)) begin
               owner_d = DATA;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               write_d = d_write;
               if (inIoWindow(d_addr[31:4], IO_BASE[31:4])) begin
                  state_d    = IO;
                  io_read_d  = !d_write;
                  io_write_d = d_write;
               end else begin
                  state_d     = MEM;
                  mem_read_d  = !d_write;
                  mem_write_d = d_write;
               end
            end else if (if_req) begin
               owner_d = FETCH;
               addr_d  = if_addr;
               wdata_d = '0;
               write_d = 1'b0;
               if (inIoWindow(if_addr[31:4], IO_BASE[31:4])) begin
                  state_d    = RESP;
                  if_done_d  = 1'b1;
                  if_rdata_d = NOP_INSTR;
                  bus_err_d  = 1'b1;
               end else begin
                  state_d    = MEM;
                  mem_read_d = 1'b1;
               end
            end
         end
         MEM: begin
            if (!mem_busy) begin
               finish     = 1'b1;
               finishData = mem_rdata;
            end else if (tmoExpired) begin
               finish    = 1'b1;
               finishErr = 1'b1;
            end
         end
         IO: begin
            finish     = 1'b1;
            finishData = io_rdata;
         end
         RESP: begin
            last_grant_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Completion is registered so done, rdata and bus_err appear together in RESP.
      if (finish) begin
         state_d     = RESP;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         bus_err_d   = finishErr;
         if (owner_q == DATA) begin
            d_done_d = 1'b1;
            if (!write_q) begin
               d_rdata_d = finishData;
            end
         end else begin
            if_done_d  = 1'b1;
            if_rdata_d = finishData;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= IDLE;
         owner_q      <= FETCH;
         last_grant_q <= FETCH;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         io_read_q    <= 1'b0;
         io_write_q   <= 1'b0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
         bus_err_q    <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         io_read_q    <= io_read_d;
         io_write_q   <= io_write_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
         bus_err_q    <= bus_err_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign io_read   = io_read_q;
   assign io_write  = io_write_q;
   assign io_addr   = addr_q[3:2];
   assign io_wdata  = wdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, arbitration, IO, wait states,
// timeout and asynchronous reset, each against hand-computed values.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        if_req, d_read, d_write, mem_busy;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata, io_rdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, io_wdata;
   logic        if_done, d_done, mem_read, mem_write, io_read, io_write, bus_err;
   logic [1:0]  io_addr;

   int testsRun = 0;
   int testsFailed = 0;
   int readCycles;
   logic sawMemWrite;
   logic [1:0] expDone;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES(8),
      .IO_BASE       (32'hFFFF_FFF0)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_done  (if_done),
      .d_read   (d_read),
      .d_write  (d_write),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_done   (d_done),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_busy (mem_busy),
      .io_read  (io_read),
      .io_write (io_write),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_rdata (io_rdata),
      .bus_err  (bus_err)
   );

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dRd,
                                input logic dWr, input logic [31:0] dAddr, input logic [31:0] dWdata);
      if_req  = ifReq;
      if_addr = ifAddr;
      d_read  = dRd;
      d_write = dWr;
      d_addr  = dAddr;
      d_wdata = dWdata;
   endtask

   // Advance one clock and land just after the edge, where registered outputs are settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      nrst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_busy = 1'b0;
      step();
      step();
      nrst = 1'b1;
   endtask

   initial begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_rdata = 32'h0;
      mem_busy  = 1'b0;
      io_rdata  = 32'h0;
      #12;
      checkOutput("reset strobes", 32'({mem_read, mem_write, io_read, io_write, if_done, d_done, bus_err}), 32'h0);
      checkOutput("reset if_rdata", if_rdata, 32'h0);
      checkOutput("reset d_rdata", d_rdata, 32'h0);
      checkOutput("reset mem_addr", mem_addr, 32'h0);
      @(posedge clk);
      #1 nrst = 1'b1;

      // Single fetch with zero wait states.
      mem_rdata = 32'h0050_0093;
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
      readCycles = 0;
      step();
      readCycles += int'(mem_read);
      checkOutput("t1 mem_read", 32'(mem_read), 32'd1);
      checkOutput("t1 mem_addr", mem_addr, 32'h100);
      checkOutput("t1 early done", 32'(if_done), 32'd0);
      step();
      readCycles += int'(mem_read);
      checkOutput("t1 if_done", 32'(if_done), 32'd1);
      checkOutput("t1 if_rdata", if_rdata, 32'h0050_0093);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      readCycles += int'(mem_read);
      checkOutput("t1 done cleared", 32'(if_done), 32'd0);
      checkOutput("t1 read cycles", 32'(readCycles), 32'd1);

      // Both requesters held: DATA, FETCH, DATA, FETCH with done every 3 cycles.
      doReset();
      mem_rdata = 32'h11;
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
      for (int s = 1; s <= 11; s++) begin
         step();
         expDone = (s == 2 || s == 8) ? 2'b01 : ((s == 5 || s == 11) ? 2'b10 : 2'b00);
         checkOutput($sformatf("t2 done cycle %0d", s), 32'({if_done, d_done}), 32'(expDone));
         if (s % 3 == 1) begin
            checkOutput($sformatf("t2 mem_addr cycle %0d", s), mem_addr,
                        (s == 1 || s == 7) ? 32'h200 : 32'h100);
         end
         if (s == 5) checkOutput("t2 if_rdata", if_rdata, 32'h11);
         if (s == 11) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      step();
      checkOutput("t2 idle after drop", 32'({mem_read, if_done, d_done}), 32'h0);

      // IO store.
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'hA5);
      sawMemWrite = 1'b0;
      step();
      sawMemWrite |= mem_write;
      checkOutput("t3 io_write", 32'(io_write), 32'd1);
      checkOutput("t3 io_addr", 32'(io_addr), 32'd3);
      checkOutput("t3 io_wdata", io_wdata, 32'hA5);
      checkOutput("t3 early done", 32'(d_done), 32'd0);
      step();
      sawMemWrite |= mem_write;
      checkOutput("t3 d_done", 32'(d_done), 32'd1);
      checkOutput("t3 io_write one cycle", 32'(io_write), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      sawMemWrite |= mem_write;
      checkOutput("t3 no mem_write", 32'(sawMemWrite), 32'd0);

      // IO load.
      io_rdata = 32'h1234;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0);
      step();
      checkOutput("io rd strobe", 32'({io_read, io_write, mem_read}), 32'h4);
      checkOutput("io rd io_addr", 32'(io_addr), 32'd1);
      step();
      checkOutput("io rd d_done", 32'(d_done), 32'd1);
      checkOutput("io rd d_rdata", d_rdata, 32'h1234);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Memory store with read and write both high behaves as a write.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF);
      step();
      checkOutput("st strobes", 32'({mem_read, mem_write, io_write}), 32'h2);
      checkOutput("st mem_addr", mem_addr, 32'h300);
      checkOutput("st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      checkOutput("st d_done", 32'(d_done), 32'd1);
      checkOutput("st rdata kept", d_rdata, 32'h1234);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Fetch from the IO window: NOP plus bus error, no strobe.
      applyStimulus(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("ill fetch done+err", 32'({if_done, bus_err}), 32'h3);
      checkOutput("ill fetch rdata", if_rdata, 32'h0000_0013);
      checkOutput("ill fetch no strobe", 32'({mem_read, io_read}), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("ill fetch err pulse", 32'({if_done, bus_err}), 32'h0);

      // Fetch just below the window goes to memory.
      mem_rdata = 32'h55;
      applyStimulus(1'b1, 32'hFFFF_FFEC, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("edge fetch mem_read", 32'({mem_read, bus_err}), 32'h2);
      step();
      checkOutput("edge fetch rdata", if_rdata, 32'h55);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Three busy cycles; address changes after grant must not leak through.
      mem_rdata = 32'hCAFE;
      mem_busy  = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         step();
         checkOutput($sformatf("t4 mem_read cycle %0d", k), 32'({mem_read, d_done}), 32'h2);
         checkOutput($sformatf("t4 mem_addr cycle %0d", k), mem_addr, 32'h40);
         d_addr = 32'h44;
         if (k == 4) mem_busy = 1'b0;
      end
      step();
      checkOutput("t4 d_done", 32'({mem_read, d_done}), 32'h1);
      checkOutput("t4 d_rdata", d_rdata, 32'hCAFE);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Stuck busy: abort after exactly 8 strobe cycles.
      mem_busy = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         step();
         checkOutput($sformatf("t5 strobe cycle %0d", k), 32'({mem_read, d_done, bus_err}), 32'h4);
      end
      step();
      checkOutput("t5 abort", 32'({mem_read, d_done, bus_err}), 32'h3);
      checkOutput("t5 rdata zero", d_rdata, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_busy = 1'b0;
      step();
      checkOutput("t5 err pulse", 32'({d_done, bus_err}), 32'h0);
      mem_rdata = 32'h77;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);
      step();
      checkOutput("t5 next strobe", 32'(mem_read), 32'd1);
      step();
      checkOutput("t5 next done", 32'({d_done, bus_err}), 32'h2);
      checkOutput("t5 next rdata", d_rdata, 32'h77);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Reset in the third busy cycle; data had the last grant, so reset must restore FETCH.
      mem_busy = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h90, 32'h0);
      step();
      step();
      step();
      #2 nrst = 1'b0;
      #1;
      checkOutput("t6 async drop", 32'(mem_read), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_busy = 1'b0;
      step();
      step();
      nrst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         checkOutput($sformatf("t6 no done %0d", k), 32'({if_done, d_done, mem_read}), 32'h0);
      end
      mem_rdata = 32'h99;
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
      step();
      checkOutput("t6 grant data addr", mem_addr, 32'h200);
      step();
      checkOutput("t6 grant data done", 32'({if_done, d_done}), 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
